// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART transmit buffer slice.
//             Holds the launch-FSM state type and the default byte width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } txbuf_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_buffer_if.sv
// ============================================================================
//  Module   : uart_tx_buffer_if
//  Purpose  : Bundles the host write port, FIFO status and transmitter
//             handshake of the UART transmit buffer.
//  Ports    : none (signals below, viewed through modports)
//             wr_en/wr_data           host write strobe and byte
//             full/empty/level        FIFO status
//             overflow                dropped-write pulse
//             tx_start/tx_data        launch pulse and byte to transmitter
//             tx_done                 transmitter completion pulse
//             busy                    launch FSM not idle
//  Modports : slave  - buffer side (drives status and launch)
//             master - host / transmitter side
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) ();

  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic                     tx_start;
  logic [DATA_W-1:0]        tx_data;
  logic                     tx_done;
  logic                     busy;

  modport slave (
    input  wr_en, wr_data, tx_done,
    output full, empty, level, overflow, tx_start, tx_data, busy
  );

  modport master (
    output wr_en, wr_data, tx_done,
    input  full, empty, level, overflow, tx_start, tx_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_buffer_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock byte FIFO. Pointers carry one extra MSB so full
//             and empty are told apart when the index bits match.
//  Ports    : clk, rst_n        clock, asynchronous active-low reset
//             wr_en, wr_data    write strobe and data (dropped when full)
//             rd_en, rd_data    pop strobe; rd_data shows the head entry
//             full, empty       occupancy flags from registered pointers
//             level             occupancy 0..DEPTH
//             overflow          1-cycle pulse after a write was dropped
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  // Flags come only from registered pointers, so a pop in the same cycle
  // never opens room for a write that arrives while full.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// ============================================================================
//  Module   : uart_tx_buffer
//  Purpose  : Byte FIFO plus launch FSM upstream of a UART transmitter.
//             Pops one byte at a time into tx_data, pulses tx_start, waits
//             for tx_done, then enforces GAP_CYC idle cycles.
//  Ports    : clk             system clock, rising edge
//             rst_n           asynchronous active-low reset
//             cts_n           active-low clear-to-send (only when the
//                             UART_TXBUF_CTS_EN macro is defined)
//             bus             uart_tx_buffer_if.slave (host write, status,
//                             transmitter handshake, busy)
//  Config   : `define UART_TXBUF_CTS_EN to gate launches on cts_n.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = UART_DATA_W,
  parameter int GAP_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef UART_TXBUF_CTS_EN
  input  logic                  cts_n,
`endif
  uart_tx_buffer_if.slave       bus
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  txbuf_state_t            state;
  txbuf_state_t            state_nxt;
  logic                    pop;
  logic                    launch_ok;
  logic [GW-1:0]           gap_cnt;
  logic [DATA_W-1:0]       tx_data_r;
  logic [DATA_W-1:0]       fifo_rd_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    fifo_overflow;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (fifo_overflow)
  );

`ifdef UART_TXBUF_CTS_EN
  // Only the pop decision looks at cts_n; a launched byte always completes.
  assign launch_ok = ~cts_n;
`else
  assign launch_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && launch_ok) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (GAP_CYC > 0) state_nxt = GAP;
          else             state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter sits at zero outside GAP so every gap starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state != GAP) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_LAST) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Captured at pop and held until the next pop, covering LAUNCH..tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tx_data_r <= '0;
    else if (pop) tx_data_r <= fifo_rd_data;
  end

  assign bus.tx_start = (state == LAUNCH);
  assign bus.tx_data  = tx_data_r;
  assign bus.busy     = (state != IDLE);
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.overflow = fifo_overflow;

endmodule

`default_nettype wire
